// File: rtl/button_debounce_bank.sv
// Multi-channel push-button conditioner: synchroniser, restart-on-bounce debounce, press/release pulses.
// Optional auto-repeat of btn_press while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_debounce_bank #(
    parameter int NUM_BTN         = 5,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_DELAY    = 20000,
    parameter int REPEAT_PERIOD   = 5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_en,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NUM_BTN-1:0][CNT_W-1:0]       count_q;
    logic [NUM_BTN-1:0]                  differ;
    logic [NUM_BTN-1:0]                  fire;

    always_comb begin
        differ = '0;
        fire   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            differ[i] = sync_q[i][SYNC_STAGES-1] != btn_level[i];
            fire[i]   = differ[i] && sample_en && (count_q[i] == DB_LAST);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0][CNT_W-1:0] hold_q;
    logic [NUM_BTN-1:0]            rep_q;
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q      <= '0;
            count_q     <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
`ifdef BTN_AUTOREPEAT_EN
            hold_q      <= '0;
            rep_q       <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                sync_q[i]      <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;

                if (!differ[i]) begin
                    count_q[i] <= '0;
                end else if (sample_en) begin
                    if (fire[i]) begin
                        count_q[i]   <= '0;
                        btn_level[i] <= sync_q[i][SYNC_STAGES-1];
                        if (sync_q[i][SYNC_STAGES-1])
                            btn_press[i] <= 1'b1;
                        else
                            btn_release[i] <= 1'b1;
                    end else begin
                        count_q[i] <= count_q[i] + CNT_W'(1);
                    end
                end

`ifdef BTN_AUTOREPEAT_EN
                // Level still 0 on the press edge itself, so this also clears the hold count there.
                if (!btn_level[i]) begin
                    hold_q[i] <= '0;
                    rep_q[i]  <= 1'b0;
                end else if (sample_en) begin
                    if (hold_q[i] == (rep_q[i] ? RP_LAST : RD_LAST)) begin
                        hold_q[i] <= '0;
                        rep_q[i]  <= 1'b1;
                        if (!fire[i])
                            btn_press[i] <= 1'b1;
                    end else begin
                        hold_q[i] <= hold_q[i] + CNT_W'(1);
                    end
                end
`endif
            end
        end
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Scoreboard bench for button_debounce_bank: stimulus queues expected pulse events, a monitor pops them.
// Define BTN_AUTOREPEAT_EN to run the auto-repeat scenario instead of the plain-debounce ones.
module tb_button_debounce_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_en = 1'b1;
    logic [4:0] btn_raw = 5'b11111;
    logic [4:0] btn_level, btn_press, btn_release;
    logic       any_press;

    typedef struct {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] lvl;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         c0;
    logic [4:0] exp_level = '0;
    bit         mon_on = 1'b0;
    bit         throttle = 1'b0;

    button_debounce_bank #(
        .NUM_BTN(5), .CNT_W(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Throttled mode: sample_en is high only on posedges whose index is a multiple of 4.
    always @(negedge clk) sample_en = throttle ? ((cyc + 1) % 4 == 0) : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [4:0] p, input logic [4:0] r);
        exp_level = (exp_level | p) & ~r;
        exp_q.push_back('{at, p, r, exp_level});
    endtask

    always @(negedge clk) begin
        if (mon_on && ((btn_press | btn_release | {4'b0, any_press}) !== 5'b0)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: press %b release %b any %b at cycle %0d, none expected",
                         btn_press, btn_release, any_press, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_cycle", cyc, mon_e.cyc);
                check("press", btn_press, mon_e.press);
                check("release", btn_release, mon_e.rel);
                check("level", btn_level, mon_e.lvl);
                check("any_press", any_press, |mon_e.press);
            end
        end
    end

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
        check("level_idle", btn_level, exp_level);
    endtask

    initial begin
        // Reset held for 3 clk with every button pressed
        repeat (3) begin
            @(negedge clk);
            mon_on = 1'b1;
            check("reset_level", btn_level, 5'b0);
            check("reset_press", btn_press, 5'b0);
            check("reset_release", btn_release, 5'b0);
            check("reset_any", any_press, 1'b0);
        end
        reset = 1'b1;
        expect_ev(cyc + 6, 5'b11111, 5'b0);
        drain();
        btn_raw = 5'b0;
        expect_ev(cyc + 6, 5'b0, 5'b11111);
        drain();

`ifndef BTN_AUTOREPEAT_EN
        // Clean press
        btn_raw[0] = 1'b1;
        expect_ev(cyc + 6, 5'b00001, 5'b0);
        drain();

        // Bounce: 3 clk high, 1 clk low, then high
        btn_raw[1] = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw[1] = 1'b0;
        @(negedge clk);
        btn_raw[1] = 1'b1;
        expect_ev(cyc + 6, 5'b00010, 5'b0);
        drain();

        // Throttled release on channel 2
        btn_raw[2] = 1'b1;
        expect_ev(cyc + 6, 5'b00100, 5'b0);
        drain();
        throttle = 1'b1;
        repeat (4) @(negedge clk);
        while (cyc % 4 != 0) @(negedge clk);
        btn_raw[2] = 1'b0;
        expect_ev(cyc + 16, 5'b0, 5'b00100);
        drain();
        throttle = 1'b0;

        // Simultaneous press on 3 and release on 4
        btn_raw[4] = 1'b1;
        expect_ev(cyc + 6, 5'b10000, 5'b0);
        drain();
        btn_raw[3] = 1'b1;
        btn_raw[4] = 1'b0;
        expect_ev(cyc + 6, 5'b01000, 5'b10000);
        drain();
`else
        // Auto-repeat: channel 0 held 30 clk
        btn_raw[0] = 1'b1;
        c0 = cyc;
        expect_ev(c0 + 6, 5'b00001, 5'b0);
        for (int k = 16; k <= 34; k += 3) expect_ev(c0 + k, 5'b00001, 5'b0);
        expect_ev(c0 + 36, 5'b0, 5'b00001);
        repeat (30) @(negedge clk);
        btn_raw[0] = 1'b0;
        drain();
        repeat (10) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
